// File: rtl/fetch_pc_sequencer.sv
// Fetch PC owner for the IF stage: selects the next PC (trap, EX flush, prediction, +4),
// issues one imem request at a time and drops responses made stale by a redirect.
module fetch_pc_sequencer #(
  parameter int                XLEN    = 32,
  parameter logic [XLEN-1:0]   PC_INIT = '0,
  parameter int                CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             trap_valid,
  input  logic [XLEN-1:0]  trap_pc,
  input  logic             ex_flush,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             predict_taken,
  input  logic [XLEN-1:0]  predict_pc,
  output logic             imem_req_valid,
  output logic [XLEN-1:0]  imem_req_addr,
  input  logic             imem_req_ready,
  input  logic             imem_resp_valid,
  input  logic [31:0]      imem_resp_data,
  output logic             if_valid,
  output logic [XLEN-1:0]  if_pc,
  output logic [31:0]      if_instr,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic            redir;
  logic [XLEN-1:0] redir_target;
  logic            req_fire;

  function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

  always_comb begin
    redir        = trap_valid | ex_flush;
    redir_target = trap_valid ? trap_pc : ex_target;
  end

  // Handshake: a request transfers on a cycle where imem_req_valid & imem_req_ready are both
  // high; once raised, valid and addr stay stable until that cycle unless a redirect or stall
  // intervenes. Each accepted request is answered by exactly one imem_resp_valid pulse.
  assign imem_req_valid = (state == S_REQ) & ~stall & ~redir & ~reset;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign fsm_state      = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_REQ;
      pc           <= PC_INIT;
      if_valid     <= 1'b0;
      if_pc        <= '0;
      if_instr     <= '0;
      redirect_cnt <= '0;
    end else begin
      if_valid <= 1'b0;

      if (redir) begin
        pc <= align4(redir_target);
        if (redirect_cnt != {CNT_W{1'b1}})
          redirect_cnt <= redirect_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end

      case (state)
        S_REQ: begin
          if (req_fire)
            state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            state <= S_REQ;
            // A redirect in the same cycle drops the response; pc is loaded above.
            if (!redir) begin
              if_valid <= 1'b1;
              if_pc    <= pc;
              if_instr <= imem_resp_data;
              pc       <= predict_taken ? align4(predict_pc) : pc + XLEN'(4);
            end
          end else if (redir) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (imem_resp_valid)
            state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Self-checking bench for fetch_pc_sequencer: directed scenarios with a scoreboard of
// expected {if_pc, if_instr} deliveries checked by a monitor on the falling edge.
module tb_fetch_pc_sequencer;
  localparam int          XLEN    = 32;
  localparam int          CNT_W   = 4;
  localparam logic [31:0] PC_INIT = 32'h0000_0000;
  localparam logic [1:0]  ST_REQ = 2'd0, ST_WAIT = 2'd1, ST_DRAIN = 2'd2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             stall = 1'b0;
  logic             trap_valid = 1'b0;
  logic [XLEN-1:0]  trap_pc = '0;
  logic             ex_flush = 1'b0;
  logic [XLEN-1:0]  ex_target = '0;
  logic             predict_taken = 1'b0;
  logic [XLEN-1:0]  predict_pc = '0;
  logic             imem_req_valid;
  logic [XLEN-1:0]  imem_req_addr;
  logic             imem_req_ready = 1'b0;
  logic             imem_resp_valid = 1'b0;
  logic [31:0]      imem_resp_data = '0;
  logic             if_valid;
  logic [XLEN-1:0]  if_pc;
  logic [31:0]      if_instr;
  logic [CNT_W-1:0] redirect_cnt;
  logic [1:0]       fsm_state;

  int               n_cmp = 0;
  int               n_err = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  logic [63:0]      exp_q[$];
  logic [63:0]      exp_item;

  fetch_pc_sequencer #(.XLEN(XLEN), .PC_INIT(PC_INIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .trap_valid(trap_valid), .trap_pc(trap_pc),
    .ex_flush(ex_flush), .ex_target(ex_target),
    .predict_taken(predict_taken), .predict_pc(predict_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .redirect_cnt(redirect_cnt), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard monitor: every delivery must match the oldest expected entry.
  always @(negedge clk) begin
    if (if_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL if_unexpected: got pc=%h instr=%h, required no delivery", if_pc, if_instr);
      end else begin
        exp_item = exp_q.pop_front();
        if ({if_pc, if_instr} !== exp_item) begin
          n_err++;
          $display("FAIL if_delivery: got pc=%h instr=%h, required pc=%h instr=%h",
                   if_pc, if_instr, exp_item[63:32], exp_item[31:0]);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic bump_cnt();
    if (exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
  endtask

  // Waits (bounded) for a transfer and checks its address; returns one cycle after acceptance.
  task automatic wait_accept(input logic [31:0] addr, input string tag);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      #1;
      if (imem_req_valid && imem_req_ready) seen = 1;
      else begin @(posedge clk); #1; end
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s_req_timeout: got no request, required addr=%h", tag, addr);
    end else if (imem_req_addr !== addr) begin
      n_err++;
      $display("FAIL %s_req_addr: got %h, required %h", tag, imem_req_addr, addr);
    end
    @(posedge clk); #1;
  endtask

  task automatic respond(input logic [31:0] addr, input logic [31:0] instr, input int lat,
                         input bit pred, input logic [31:0] ppc, input bit deliver);
    for (int i = 0; i < lat; i++) cyc();
    imem_resp_valid = 1'b1;
    imem_resp_data  = instr;
    predict_taken   = pred;
    predict_pc      = ppc;
    if (deliver) exp_q.push_back({addr, instr});
    cyc();
    imem_resp_valid = 1'b0;
    predict_taken   = 1'b0;
  endtask

  task automatic fetch_one(input logic [31:0] addr, input string tag);
    wait_accept(addr, tag);
    respond(addr, $urandom, $urandom_range(0, 3), 1'b0, '0, 1'b1);
  endtask

  task automatic test_reset();
    imem_req_ready = 1'b1;
    reset = 1'b1;
    cyc();
    #1;
    n_cmp++;
    if (imem_req_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_req_valid: got %b, required 0", imem_req_valid);
    end
    cyc();
    n_cmp++;
    if ({if_valid, if_pc, if_instr, redirect_cnt, fsm_state, imem_req_addr} !==
        {1'b0, 32'h0, 32'h0, {CNT_W{1'b0}}, ST_REQ, PC_INIT}) begin
      n_err++;
      $display("FAIL reset_state: got v=%b pc=%h instr=%h cnt=%0d st=%0d addr=%h, required 0/0/0/0/REQ/%h",
               if_valid, if_pc, if_instr, redirect_cnt, fsm_state, imem_req_addr, PC_INIT);
    end
    reset = 1'b0;
    exp_cnt = '0;
  endtask

  task automatic test_sequential();
    wait_accept(32'h0, "seq0"); respond(32'h0, 32'h13, 0, 1'b0, '0, 1'b1);
    wait_accept(32'h4, "seq1"); respond(32'h4, 32'h13, 0, 1'b0, '0, 1'b1);
  endtask

  task automatic test_predict();
    wait_accept(32'h8, "pred0"); respond(32'h8, 32'h13, 0, 1'b1, 32'h100, 1'b1);
    fetch_one(32'h100, "pred_tgt");
    wait_accept(32'h104, "pred1"); respond(32'h104, 32'h0000_006f, 1, 1'b1, 32'h203, 1'b1);
    fetch_one(32'h200, "pred_align");
  endtask

  task automatic test_flush_wait();
    wait_accept(32'h204, "flush");
    ex_flush = 1'b1; ex_target = 32'h2000;
    cyc();
    ex_flush = 1'b0; bump_cnt();
    #1;
    n_cmp++;
    if ({fsm_state, imem_req_valid, imem_req_addr, redirect_cnt} !== {ST_DRAIN, 1'b0, 32'h2000, exp_cnt}) begin
      n_err++;
      $display("FAIL flush_drain: got st=%0d v=%b addr=%h cnt=%0d, required DRAIN/0/2000/%0d",
               fsm_state, imem_req_valid, imem_req_addr, redirect_cnt, exp_cnt);
    end
    cyc(); cyc();
    respond(32'h204, 32'hdead_beef, 0, 1'b0, '0, 1'b0);
    n_cmp++;
    if (fsm_state !== ST_REQ) begin
      n_err++; $display("FAIL flush_to_req: got st=%0d, required %0d", fsm_state, ST_REQ);
    end
    fetch_one(32'h2000, "flush_tgt");
    // A second redirect while draining overrides the first target.
    wait_accept(32'h2004, "drain2");
    ex_flush = 1'b1; ex_target = 32'h2100;
    cyc();
    ex_flush = 1'b0; trap_valid = 1'b1; trap_pc = 32'h3001;
    cyc();
    trap_valid = 1'b0; bump_cnt(); bump_cnt();
    n_cmp++;
    if ({fsm_state, imem_req_addr, redirect_cnt} !== {ST_DRAIN, 32'h3000, exp_cnt}) begin
      n_err++;
      $display("FAIL drain_overwrite: got st=%0d addr=%h cnt=%0d, required DRAIN/3000/%0d",
               fsm_state, imem_req_addr, redirect_cnt, exp_cnt);
    end
    respond(32'h2004, 32'h1111_2222, 1, 1'b0, '0, 1'b0);
    fetch_one(32'h3000, "drain_tgt");
  endtask

  task automatic test_trap_flush_resp();
    wait_accept(32'h3004, "trap");
    trap_valid = 1'b1; trap_pc = 32'h8000_0000;
    ex_flush = 1'b1; ex_target = 32'h40;
    respond(32'h3004, 32'h5555_aaaa, 0, 1'b1, 32'h500, 1'b0);
    trap_valid = 1'b0; ex_flush = 1'b0; bump_cnt();
    n_cmp++;
    if ({fsm_state, imem_req_addr, redirect_cnt} !== {ST_REQ, 32'h8000_0000, exp_cnt}) begin
      n_err++;
      $display("FAIL trap_resp: got st=%0d addr=%h cnt=%0d, required REQ/80000000/%0d",
               fsm_state, imem_req_addr, redirect_cnt, exp_cnt);
    end
    fetch_one(32'h8000_0000, "trap_tgt");
  endtask

  task automatic test_stall_backpressure();
    stall = 1'b1; predict_taken = 1'b1; predict_pc = 32'h700;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if (imem_req_valid !== 1'b0) begin
        n_err++; $display("FAIL stall_req_valid[%0d]: got %b, required 0", i, imem_req_valid);
      end
      @(posedge clk); #1;
    end
    stall = 1'b0; predict_taken = 1'b0; imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h8000_0004}) begin
        n_err++;
        $display("FAIL backpressure[%0d]: got v=%b addr=%h, required 1/80000004", i, imem_req_valid, imem_req_addr);
      end
      @(posedge clk); #1;
    end
    imem_req_ready = 1'b1;
    fetch_one(32'h8000_0004, "bp_release");
    wait_accept(32'h8000_0008, "stall_wait");
    stall = 1'b1;
    respond(32'h8000_0008, 32'h0000_0033, 1, 1'b0, '0, 1'b1);
    #1;
    n_cmp++;
    if ({fsm_state, imem_req_valid} !== {ST_REQ, 1'b0}) begin
      n_err++; $display("FAIL stall_after_resp: got st=%0d v=%b, required REQ/0", fsm_state, imem_req_valid);
    end
    stall = 1'b0;
    fetch_one(32'h8000_000c, "stall_resume");
  endtask

  task automatic test_wrap_align();
    ex_flush = 1'b1; ex_target = 32'hffff_fffe;
    #1;
    n_cmp++;
    if (imem_req_valid !== 1'b0) begin
      n_err++; $display("FAIL redir_req_valid: got %b, required 0", imem_req_valid);
    end
    cyc();
    ex_flush = 1'b0; bump_cnt();
    fetch_one(32'hffff_fffc, "wrap_top");
    fetch_one(32'h0000_0000, "wrap_zero");
    ex_flush = 1'b1; ex_target = 32'h1003;
    cyc();
    ex_flush = 1'b0; bump_cnt();
    fetch_one(32'h1000, "misalign");
  endtask

  task automatic test_saturation();
    ex_flush = 1'b1; ex_target = 32'h4000;
    for (int i = 0; i < 12; i++) begin
      cyc();
      bump_cnt();
    end
    ex_flush = 1'b0;
    n_cmp++;
    if ({redirect_cnt, exp_cnt} !== {{CNT_W{1'b1}}, {CNT_W{1'b1}}}) begin
      n_err++; $display("FAIL cnt_saturate: got %0d, required %0d (model %0d)", redirect_cnt, {CNT_W{1'b1}}, exp_cnt);
    end
    fetch_one(32'h4000, "sat_tgt");
  endtask

  task automatic test_reset_mid();
    wait_accept(32'h4004, "mid");
    reset = 1'b1;
    #1;
    n_cmp++;
    if (imem_req_valid !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_req_valid: got %b, required 0", imem_req_valid);
    end
    @(posedge clk); #1;
    reset = 1'b0; imem_req_ready = 1'b0; exp_cnt = '0;
    respond(32'h4004, 32'h0bad_0bad, 0, 1'b0, '0, 1'b0);
    n_cmp++;
    if ({fsm_state, imem_req_addr, redirect_cnt, if_pc, if_instr} !==
        {ST_REQ, PC_INIT, exp_cnt, 32'h0, 32'h0}) begin
      n_err++;
      $display("FAIL mid_reset_state: got st=%0d addr=%h cnt=%0d if_pc=%h if_instr=%h, required REQ/%h/0/0/0",
               fsm_state, imem_req_addr, redirect_cnt, if_pc, if_instr, PC_INIT);
    end
    imem_req_ready = 1'b1;
    fetch_one(PC_INIT, "mid_restart");
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_predict();
    test_flush_wait();
    test_trap_flush_resp();
    test_stall_backpressure();
    test_wrap_align();
    test_saturation();
    test_reset_mid();
    cyc(); cyc();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_pc_sequencer.md
Name: fetch_pc_sequencer

Overview:
Owns the fetch PC and sequences instruction-memory requests for the IF stage of the out-of-order core. It arbitrates between PC sources: commit trap, EX misprediction flush, IF branch prediction and sequential +4. It tracks one outstanding imem request at a time. Responses made stale by a redirect are discarded, so decode only sees instructions on the correct path.

Parameters:
XLEN, 32, PC and address width
PC_INIT, 32'h0000_0000, PC loaded on reset
CNT_W, 16, width of the saturating redirect counter

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
stall  in  1  backend stall; blocks issue of new imem requests
trap_valid  in  1  commit-stage trap/mret redirect (highest priority)
trap_pc  in  XLEN  trap redirect target
ex_flush  in  1  EX branch misprediction redirect
ex_target  in  XLEN  corrected branch target
predict_taken  in  1  predictor says the PC of the current response is a taken branch
predict_pc  in  XLEN  predicted target
imem_req_valid  out  1  request valid
imem_req_addr  out  XLEN  request address (always equal to pc)
imem_req_ready  in  1  imem accepts the request
imem_resp_valid  in  1  response valid (one-cycle pulse per accepted request)
imem_resp_data  in  32  instruction word
if_valid  out  1  instruction valid to decode (one-cycle pulse)
if_pc  out  XLEN  PC of if_instr
if_instr  out  32  fetched instruction
redirect_cnt  out  CNT_W  number of trap/flush redirects taken, saturating

Behaviour:
- States: REQ (request at pc may be issued), WAIT (request accepted, response pending), DRAIN (outstanding response is stale and will be dropped).
- Reset, sync high, overrides everything:
  - pc=PC_INIT, state=REQ.
  - if_valid=0, if_pc=0, if_instr=0, redirect_cnt=0.
  - imem_req_valid=0 during the reset cycle.
- Every PC load forces pc[1:0]=2'b00. pc+4 wraps modulo 2^XLEN.
- Redirect: redir = trap_valid | ex_flush. Target is trap_pc if trap_valid, else ex_target. A redirect in any state:
  - loads pc with the target;
  - forces if_valid=0 next cycle;
  - increments redirect_cnt, saturating at all-ones.
- REQ:
  - imem_req_valid = ~stall & ~redir (combinational).
  - On valid&ready: go to WAIT; pc unchanged.
  - A redirect in REQ never issues, so the new target is requested next cycle.
- WAIT, resp_valid=1, no redirect:
  - Next cycle: if_valid=1, if_pc=pc, if_instr=resp_data.
  - pc <= predict_taken ? predict_pc : pc+4 (predict_* are sampled this cycle).
  - Go to REQ. Turnaround is one cycle per instruction, so the peak rate is one instruction every 2 cycles with zero-wait imem.
- WAIT, resp_valid=1 and redirect in the same cycle: the response is dropped, pc=target, go to REQ.
- WAIT, redirect with no response: go to DRAIN.
- DRAIN:
  - imem_req_valid=0.
  - On resp_valid: drop the response and go to REQ (pc already holds the target).
  - A further redirect in DRAIN overwrites pc; stay in DRAIN until the single pending response arrives.
- Priority: trap > ex_flush > predict_taken > +4.
- stall only gates new requests. An in-flight response is still delivered; the backend reserves space for one response.
- predict_taken is ignored outside WAIT&resp_valid.
- imem_req_addr == pc in all states.

Test Plan:
- Reset sequence: reset high 2 cycles, release, imem ready, 0-wait responses 0x13,0x13,0x13 → requests at 0x0,0x4,0x8; if_valid pulses with if_pc 0x0,0x4,0x8.
- Prediction: response for pc 0x8 with predict_taken=1, predict_pc=0x100 → next request at 0x100, if_pc=0x8 delivered.
- Flush while waiting: request at 0x10 accepted, ex_flush=1, ex_target=0x2000 before the response, response arrives 3 cycles later → no if_valid, state passes through DRAIN, next request at 0x2000, redirect_cnt=1.
- Simultaneous trap and flush with the response: trap_pc=0x8000_0000, ex_target=0x40 in the cycle resp_valid=1 → response dropped, next request at 0x8000_0000, redirect_cnt +1 only.
- Stall and backpressure:
  - stall=1 for 5 cycles in REQ → imem_req_valid=0 throughout.
  - imem_req_ready=0 for 3 cycles → request held stable at the same addr.
- Wrap, misalignment and reset mid-operation:
  - pc=0xFFFF_FFFC, no prediction → next request 0x0.
  - ex_target=0x1003 → request 0x1000.
  - Reset asserted in WAIT → pc=PC_INIT, state=REQ, the late response is ignored.
